// File: rtl/alu_issue_stage.sv
// ID/EX stage feeding the ALU: registers decoded fields, maps opcode/funct fields to alu_op,
// selects operands and forwards EX/MEM and MEM/WB results into rs1/rs2.
module alu_issue_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic [6:0]            id_opcode,
  input  logic [2:0]            id_funct3,
  input  logic                  id_funct7_5,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  exm_reg_write,
  input  logic [REG_ADDR_W-1:0] exm_rd_addr,
  input  logic [XLEN-1:0]       exm_result,
  input  logic                  mwb_reg_write,
  input  logic [REG_ADDR_W-1:0] mwb_rd_addr,
  input  logic [XLEN-1:0]       mwb_result,
  output logic                  ex_valid,
  output logic [3:0]            alu_op,
  output logic [XLEN-1:0]       in_a,
  output logic [XLEN-1:0]       in_b,
  output logic [XLEN-1:0]       ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_reg_write
);

  // Operand source select; SRC_REG is 0 so a cleared stage reads x0 (never forwarded).
  localparam logic [1:0] SRC_REG  = 2'd0;
  localparam logic [1:0] SRC_PC   = 2'd1;
  localparam logic [1:0] SRC_IMM  = 2'd2;
  localparam logic [1:0] SRC_ZERO = 2'd3;

  logic [3:0] dec_alu_op;
  logic [1:0] dec_src_a;
  logic [1:0] dec_src_b;
  logic       dec_reg_write;

  always_comb begin
    dec_alu_op    = 4'b0000;
    dec_src_a     = SRC_ZERO;
    dec_src_b     = SRC_ZERO;
    dec_reg_write = 1'b0;
    case (id_opcode)
      7'b0110011: begin
        dec_alu_op    = {id_funct7_5, id_funct3};
        dec_src_a     = SRC_REG;
        dec_src_b     = SRC_REG;
        dec_reg_write = 1'b1;
      end
      7'b0010011: begin
        // Only shifts take bit 30 as an opcode bit; otherwise it is immediate data.
        dec_alu_op    = {(id_funct3 == 3'b101) ? id_funct7_5 : 1'b0, id_funct3};
        dec_src_a     = SRC_REG;
        dec_src_b     = SRC_IMM;
        dec_reg_write = 1'b1;
      end
      7'b0000011: begin
        dec_src_a     = SRC_REG;
        dec_src_b     = SRC_IMM;
        dec_reg_write = 1'b1;
      end
      7'b0100011: begin
        dec_src_a = SRC_REG;
        dec_src_b = SRC_IMM;
      end
      7'b1100011: begin
        dec_alu_op = 4'b1000;
        dec_src_a  = SRC_REG;
        dec_src_b  = SRC_REG;
      end
      7'b0110111: begin
        dec_src_b     = SRC_IMM;
        dec_reg_write = 1'b1;
      end
      7'b0010111: begin
        dec_src_a     = SRC_PC;
        dec_src_b     = SRC_IMM;
        dec_reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  logic                  valid_reg;
  logic                  reg_write_reg;
  logic [3:0]            alu_op_reg;
  logic [1:0]            src_a_reg;
  logic [1:0]            src_b_reg;
  logic [XLEN-1:0]       pc_reg;
  logic [XLEN-1:0]       imm_reg;
  logic [XLEN-1:0]       rs1_data_reg;
  logic [XLEN-1:0]       rs2_data_reg;
  logic [REG_ADDR_W-1:0] rs1_addr_reg;
  logic [REG_ADDR_W-1:0] rs2_addr_reg;
  logic [REG_ADDR_W-1:0] rd_addr_reg;

  logic [REG_ADDR_W-1:0] rs_addr  [2];
  logic [XLEN-1:0]       rs_data  [2];
  logic [XLEN-1:0]       fwd_data [2];

  assign rs_addr[0] = rs1_addr_reg;
  assign rs_addr[1] = rs2_addr_reg;
  assign rs_data[0] = rs1_data_reg;
  assign rs_data[1] = rs2_data_reg;

  // EX/MEM is younger than MEM/WB, so it wins when both target the same register.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic exm_hit;
    logic mwb_hit;
    assign exm_hit = exm_reg_write && (exm_rd_addr != '0) && (exm_rd_addr == rs_addr[gi]);
    assign mwb_hit = mwb_reg_write && (mwb_rd_addr != '0) && (mwb_rd_addr == rs_addr[gi]);
    assign fwd_data[gi] = exm_hit ? exm_result : (mwb_hit ? mwb_result : rs_data[gi]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      valid_reg     <= 1'b0;
      reg_write_reg <= 1'b0;
      alu_op_reg    <= '0;
      src_a_reg     <= '0;
      src_b_reg     <= '0;
      pc_reg        <= '0;
      imm_reg       <= '0;
      rs1_data_reg  <= '0;
      rs2_data_reg  <= '0;
      rs1_addr_reg  <= '0;
      rs2_addr_reg  <= '0;
      rd_addr_reg   <= '0;
    end else if (stall) begin
      // Absorb results retiring while held so they are not missed once they leave the pipe.
      rs1_data_reg <= fwd_data[0];
      rs2_data_reg <= fwd_data[1];
    end else begin
      valid_reg     <= id_valid;
      reg_write_reg <= id_valid & dec_reg_write;
      alu_op_reg    <= dec_alu_op;
      src_a_reg     <= dec_src_a;
      src_b_reg     <= dec_src_b;
      pc_reg        <= id_pc;
      imm_reg       <= id_imm;
      rs1_data_reg  <= id_rs1_data;
      rs2_data_reg  <= id_rs2_data;
      rs1_addr_reg  <= id_rs1_addr;
      rs2_addr_reg  <= id_rs2_addr;
      rd_addr_reg   <= id_rd_addr;
    end
  end

  always_comb begin
    case (src_a_reg)
      SRC_REG: in_a = fwd_data[0];
      SRC_PC:  in_a = pc_reg;
      SRC_IMM: in_a = imm_reg;
      default: in_a = '0;
    endcase
    case (src_b_reg)
      SRC_REG: in_b = fwd_data[1];
      SRC_PC:  in_b = pc_reg;
      SRC_IMM: in_b = imm_reg;
      default: in_b = '0;
    endcase
  end

  assign ex_valid      = valid_reg;
  assign alu_op        = alu_op_reg;
  assign ex_store_data = fwd_data[1];
  assign ex_rd_addr    = rd_addr_reg;
  assign ex_reg_write  = reg_write_reg & valid_reg & (rd_addr_reg != '0);

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: instruction-level model compared every cycle, plus directed literal checks.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_funct7_5;
  logic        stall, flush;
  logic        exm_reg_write, mwb_reg_write;
  logic [4:0]  exm_rd_addr, mwb_rd_addr;
  logic [31:0] exm_result, mwb_result;
  logic        ex_valid, ex_reg_write;
  logic [3:0]  alu_op;
  logic [31:0] in_a, in_b, ex_store_data;
  logic [4:0]  ex_rd_addr;

  int checks = 0;
  int errors = 0;

  alu_issue_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
    .stall(stall), .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd_addr(mwb_rd_addr), .mwb_result(mwb_result),
    .ex_valid(ex_valid), .alu_op(alu_op), .in_a(in_a), .in_b(in_b),
    .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end else
      $display("ok   %s = 0x%08h at %0t", name, act, $time);
  endtask

  // Model: the instruction currently held in the stage, as raw decode fields.
  logic        m_valid;
  logic [31:0] m_pc, m_imm, m_rs1d, m_rs2d;
  logic [4:0]  m_rs1a, m_rs2a, m_rd;
  logic [6:0]  m_opc;
  logic [2:0]  m_f3;
  logic        m_f7;

  logic [31:0] f1, f2, exp_a, exp_b;
  logic [3:0]  exp_op;
  logic        exp_rw;

  always_comb begin
    f1 = m_rs1d;
    f2 = m_rs2d;
    if (mwb_reg_write && mwb_rd_addr != 0 && mwb_rd_addr == m_rs1a) f1 = mwb_result;
    if (exm_reg_write && exm_rd_addr != 0 && exm_rd_addr == m_rs1a) f1 = exm_result;
    if (mwb_reg_write && mwb_rd_addr != 0 && mwb_rd_addr == m_rs2a) f2 = mwb_result;
    if (exm_reg_write && exm_rd_addr != 0 && exm_rd_addr == m_rs2a) f2 = exm_result;
    exp_op = 4'b0000;
    exp_a  = 32'h0;
    exp_b  = 32'h0;
    exp_rw = 1'b0;
    case (m_opc)
      7'b0110011: begin exp_op = {m_f7, m_f3}; exp_a = f1; exp_b = f2; exp_rw = 1'b1; end
      7'b0010011: begin
        exp_op = {(m_f3 == 3'b101) && m_f7, m_f3}; exp_a = f1; exp_b = m_imm; exp_rw = 1'b1;
      end
      7'b0000011: begin exp_a = f1; exp_b = m_imm; exp_rw = 1'b1; end
      7'b0100011: begin exp_a = f1; exp_b = m_imm; end
      7'b1100011: begin exp_op = 4'b1000; exp_a = f1; exp_b = f2; end
      7'b0110111: begin exp_b = m_imm; exp_rw = 1'b1; end
      7'b0010111: begin exp_a = m_pc; exp_b = m_imm; exp_rw = 1'b1; end
      default: ;
    endcase
  end

  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      m_valid <= 0; m_pc <= 0; m_imm <= 0; m_rs1d <= 0; m_rs2d <= 0;
      m_rs1a <= 0; m_rs2a <= 0; m_rd <= 0; m_opc <= 0; m_f3 <= 0; m_f7 <= 0;
    end else if (stall) begin
      m_rs1d <= f1;
      m_rs2d <= f2;
    end else begin
      m_valid <= id_valid; m_pc <= id_pc; m_imm <= id_imm;
      m_rs1d <= id_rs1_data; m_rs2d <= id_rs2_data;
      m_rs1a <= id_rs1_addr; m_rs2a <= id_rs2_addr; m_rd <= id_rd_addr;
      m_opc <= id_opcode; m_f3 <= id_funct3; m_f7 <= id_funct7_5;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model.ex_valid", 32'(ex_valid), 32'(m_valid));
      chk("model.ex_reg_write", 32'(ex_reg_write), 32'(m_valid && exp_rw && m_rd != 0));
      if (m_valid) begin
        chk("model.alu_op", 32'(alu_op), 32'(exp_op));
        chk("model.in_a", in_a, exp_a);
        chk("model.in_b", in_b, exp_b);
        chk("model.store_data", ex_store_data, f2);
        chk("model.rd_addr", 32'(ex_rd_addr), 32'(m_rd));
      end
    end
  end

  task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input logic [31:0] pc, input logic [4:0] rs1a, input logic [31:0] rs1d,
                       input logic [4:0] rs2a, input logic [31:0] rs2d, input logic [31:0] imm,
                       input logic [4:0] rd);
    id_valid = v; id_opcode = opc; id_funct3 = f3; id_funct7_5 = f7; id_pc = pc;
    id_rs1_addr = rs1a; id_rs1_data = rs1d; id_rs2_addr = rs2a; id_rs2_data = rs2d;
    id_imm = imm; id_rd_addr = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ex_valid"}, 32'(ex_valid), 0);
    chk({tag, ".alu_op"}, 32'(alu_op), 0);
    chk({tag, ".in_a"}, in_a, 0);
    chk({tag, ".in_b"}, in_b, 0);
    chk({tag, ".store_data"}, ex_store_data, 0);
    chk({tag, ".rd_addr"}, 32'(ex_rd_addr), 0);
    chk({tag, ".reg_write"}, 32'(ex_reg_write), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; stall = 0; flush = 0;
    exm_reg_write = 0; exm_rd_addr = 0; exm_result = 0;
    mwb_reg_write = 0; mwb_rd_addr = 0; mwb_result = 0;
    drive(0, 7'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_zero("reset");
    step();
    chk_zero("idle");

    // OP SRA
    drive(1, 7'b0110011, 3'b101, 1, 32'h0, 1, 32'h80000000, 2, 32'h4, 32'h0, 3);
    step();
    chk("sra.alu_op", 32'(alu_op), 32'hD);
    chk("sra.in_a", in_a, 32'h80000000);
    chk("sra.in_b", in_b, 32'h4);
    chk("sra.reg_write", 32'(ex_reg_write), 1);

    drive(1, 7'b0010111, 3'b000, 0, 32'h1000, 1, 32'h55, 2, 32'h66, 32'h2000, 4);
    step();
    chk("auipc.in_a", in_a, 32'h1000);
    chk("auipc.in_b", in_b, 32'h2000);
    chk("auipc.alu_op", 32'(alu_op), 0);

    drive(1, 7'b0110111, 3'b000, 0, 32'h1000, 1, 32'h55, 2, 32'h66, 32'hABCDE000, 4);
    step();
    chk("lui.in_a", in_a, 0);
    chk("lui.in_b", in_b, 32'hABCDE000);

    drive(1, 7'b0010011, 3'b101, 1, 0, 1, 32'h55, 2, 32'h66, 32'h403, 4);
    step();
    chk("srai.alu_op", 32'(alu_op), 32'hD);
    drive(1, 7'b0010011, 3'b000, 1, 0, 1, 32'h55, 2, 32'h66, 32'hFFFFFC00, 4);
    step();
    chk("addi.alu_op", 32'(alu_op), 0);
    chk("addi.in_b", in_b, 32'hFFFFFC00);

    drive(1, 7'b0100011, 3'b010, 0, 0, 1, 32'h100, 2, 32'hCAFE, 32'h8, 7);
    step();
    chk("store.reg_write", 32'(ex_reg_write), 0);
    chk("store.store_data", ex_store_data, 32'hCAFE);
    chk("store.in_b", in_b, 32'h8);

    drive(1, 7'b1100011, 3'b001, 0, 0, 1, 32'h9, 2, 32'h3, 32'h10, 0);
    step();
    chk("branch.alu_op", 32'(alu_op), 32'h8);
    chk("branch.in_b", in_b, 32'h3);

    drive(1, 7'b1111111, 3'b111, 1, 32'h40, 1, 32'h9, 2, 32'h3, 32'h10, 5);
    step();
    chk("unknown.ex_valid", 32'(ex_valid), 1);
    chk("unknown.in_a", in_a, 0);
    chk("unknown.in_b", in_b, 0);
    chk("unknown.reg_write", 32'(ex_reg_write), 0);

    drive(1, 7'b0110011, 3'b000, 0, 0, 1, 32'h1, 2, 32'h2, 0, 0);
    step();
    chk("rd0.reg_write", 32'(ex_reg_write), 0);

    drive(0, 7'b0110011, 3'b000, 0, 0, 1, 32'h1, 2, 32'h2, 0, 3);
    step();
    chk("bubble.ex_valid", 32'(ex_valid), 0);
    chk("bubble.reg_write", 32'(ex_reg_write), 0);

    // Forwarding priority
    drive(1, 7'b0110011, 3'b000, 0, 0, 5, 32'h1, 7, 32'h2, 0, 8);
    step();
    exm_reg_write = 1; exm_rd_addr = 5; exm_result = 32'h11;
    mwb_reg_write = 1; mwb_rd_addr = 5; mwb_result = 32'h22;
    #1 chk("fwd.exm", in_a, 32'h11);
    exm_reg_write = 0;
    #1 chk("fwd.mwb", in_a, 32'h22);
    exm_reg_write = 1; exm_rd_addr = 0; mwb_rd_addr = 0;
    #1 chk("fwd.x0", in_a, 32'h1);
    exm_reg_write = 0; mwb_reg_write = 0;

    // Stall with a writeback retiring in the first stall cycle only
    drive(1, 7'b0110011, 3'b000, 0, 0, 1, 32'h5, 6, 32'h3, 0, 9);
    step();
    stall = 1;
    drive(1, 7'b0110011, 3'b000, 1, 0, 2, 32'hDEAD, 3, 32'hBEEF, 0, 12);
    mwb_reg_write = 1; mwb_rd_addr = 6; mwb_result = 32'h77;
    #1 chk("stall0.store_data", ex_store_data, 32'h77);
    for (int i = 1; i <= 3; i++) begin
      step();
      if (i == 1) mwb_reg_write = 0;
      if (i == 3) stall = 0;
      chk("stall.store_data", ex_store_data, 32'h77);
      chk("stall.in_b", in_b, 32'h77);
      chk("stall.in_a", in_a, 32'h5);
      chk("stall.rd_addr", 32'(ex_rd_addr), 9);
      chk("stall.alu_op", 32'(alu_op), 0);
    end

    // Flush beats stall
    drive(1, 7'b0110011, 3'b000, 0, 0, 1, 32'h5, 2, 32'h6, 0, 10);
    step();
    stall = 1; flush = 1;
    step();
    chk("flush.ex_valid", 32'(ex_valid), 0);
    chk("flush.reg_write", 32'(ex_reg_write), 0);
    chk("flush.alu_op", 32'(alu_op), 0);
    chk("flush.in_a", in_a, 0);
    stall = 0; flush = 0;

    // Asynchronous reset mid-cycle with valid data held at the inputs
    drive(1, 7'b0110011, 3'b000, 0, 0, 1, 32'h123, 2, 32'h456, 0, 2);
    step();
    chk("pre_rst.ex_valid", 32'(ex_valid), 1);
    #2 rst = 1;
    #1 chk_zero("async_rst");
    #2 rst = 0;
    step();
    chk("post_rst.ex_valid", 32'(ex_valid), 1);
    chk("post_rst.in_a", in_a, 32'h123);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage directly upstream of the ALU. Registers decoded instruction fields and maps opcode/funct3/funct7[5] to a 4-bit alu_op.
- Selects ALU operands from rs1/rs2, pc, imm or zero. Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Outputs drive alu_op, in_a and in_b of the ALU interface.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  decode slot holds an instruction
- id_pc  in  XLEN  instruction PC
- id_rs1_data  in  XLEN  register-file rs1 read data
- id_rs2_data  in  XLEN  register-file rs2 read data
- id_imm  in  XLEN  sign-extended immediate, already formatted by decode
- id_rs1_addr  in  REG_ADDR_W  rs1 index
- id_rs2_addr  in  REG_ADDR_W  rs2 index
- id_rd_addr  in  REG_ADDR_W  rd index
- id_opcode  in  7  instruction opcode field
- id_funct3  in  3  funct3 field
- id_funct7_5  in  1  instruction bit 30
- stall  in  1  hold stage contents
- flush  in  1  replace stage contents with a bubble
- exm_reg_write  in  1  EX/MEM instruction writes rd
- exm_rd_addr  in  REG_ADDR_W  EX/MEM rd index
- exm_result  in  XLEN  EX/MEM result
- mwb_reg_write  in  1  MEM/WB instruction writes rd
- mwb_rd_addr  in  REG_ADDR_W  MEM/WB rd index
- mwb_result  in  XLEN  MEM/WB writeback value
- ex_valid  out  1  stage holds a valid instruction
- alu_op  out  4  ALU operation
- in_a  out  XLEN  ALU operand A
- in_b  out  XLEN  ALU operand B
- ex_store_data  out  XLEN  forwarded rs2 value
- ex_rd_addr  out  REG_ADDR_W  rd index
- ex_reg_write  out  1  instruction writes rd

Behaviour:
- alu_op encoding is {funct7_5, funct3}:
  - ADD=0000, SUB=1000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, SRA=1101, OR=0110, AND=0111.
- Decode is registered on the rising clk edge. Table per opcode:
  - OP (0110011): alu_op {f7_5,f3}; A=rs1; B=rs2; reg_write=1.
  - OP-IMM (0010011): alu_op {f3==101 ? f7_5 : 0, f3}; A=rs1; B=imm; reg_write=1.
  - LOAD (0000011): ADD; A=rs1; B=imm; reg_write=1.
  - STORE (0100011): ADD; A=rs1; B=imm; reg_write=0.
  - BRANCH (1100011): SUB; A=rs1; B=rs2; reg_write=0.
  - LUI (0110111): ADD; A=zero; B=imm; reg_write=1.
  - AUIPC (0010111): ADD; A=pc; B=imm; reg_write=1.
  - Any other opcode: ADD; A=zero; B=zero; reg_write=0; valid still follows id_valid.
  - id_valid=0 captures a bubble: valid=0, reg_write=0.
- ex_reg_write = stored reg_write AND ex_valid. An rd of 0 never writes.
- Forwarding is combinational from registered fields to outputs. It applies only when the operand source is rs1/rs2.
  - Priority: EX/MEM match (exm_reg_write, exm_rd≠0, exm_rd==rs) → exm_result.
  - Else MEM/WB match (same conditions) → mwb_result.
  - Else the stored register data.
- ex_store_data is always the forwarded rs2 value.
- Latency: one cycle from id_* to outputs. Operand values also respond combinationally to forwarding inputs in the same cycle.
- stall=1, flush=0:
  - All fields held.
  - Stored rs1/rs2 data reloaded each cycle with the forwarded value, so writebacks retiring during a stall are not lost.
- flush=1: bubble loaded (valid=0, reg_write=0, all fields 0). Flush beats stall.
- rst asserted at any time: all registers cleared immediately, with no clock needed.
  - Outputs become: ex_valid=0, alu_op=0000, ex_rd_addr=0, ex_reg_write=0, in_a=0, in_b=0, ex_store_data=0.
  - x0 is never forwarded, so these values hold.
- First edge after rst deasserts captures id_* normally.

Test Plan:
- Reset then idle → all outputs 0. Assert rst mid-stream with valid data held → outputs 0 before the next clk edge.
- OP, f3=101, f7_5=1, rs1=0x80000000, rs2=4 → next cycle alu_op=1101, in_a=0x80000000, in_b=4, ex_reg_write=1.
- AUIPC, pc=0x1000, imm=0x2000 → in_a=0x1000, in_b=0x2000, alu_op=0000. LUI, imm=0xABCDE000 → in_a=0.
- Stage rs1=x5 (stored 1); exm rd=5, result 0x11; mwb rd=5, result 0x22 → in_a=0x11. Drop exm match → 0x22. Set rd=0 on both → stored 1.
- stall 3 cycles while mwb writes x6=0x77 in stall cycle 1 only, stage rs2=x6 → ex_store_data=0x77 in all later stall cycles; no other field changes.
- stall=1 and flush=1 together with a valid ADD staged → next cycle ex_valid=0, ex_reg_write=0, alu_op=0000.
